// File: rtl/noc_tx_port_queue_if.sv
// Packet type shared by the core, the egress queue and the mesh, plus the bundle of
// enqueue/transmit handshake signals used between them.
`timescale 1ns/1ps

package noc_tx_pkg;
  localparam int SRC_W = 4;

  typedef enum logic [1:0] {
    MSG_STATUS = 2'd0,
    MSG_REQ    = 2'd1,
    MSG_RESP   = 2'd2,
    MSG_EVENT  = 2'd3
  } msg_type_t;

  typedef struct packed {
    msg_type_t        msg_type;
    logic [SRC_W-1:0] src_id;
    logic [3:0]       dst_id;
    logic [15:0]      payload;
  } noc_packet_t;
endpackage

// Handshake rule on both sides: a transfer happens on a rising clk edge where valid
// and ready are both 1; the offering side holds valid and its data stable until then.
interface noc_tx_port_queue_if;
  import noc_tx_pkg::*;

  logic              enq_valid;
  logic              enq_ready;
  noc_packet_t       enq_pkt;
  logic [3:0]        enq_port_mask;
  noc_packet_t [3:0] tx_pkt;
  logic [3:0]        tx_valid;
  logic [3:0]        tx_ready;

  modport master (
    output enq_valid, enq_pkt, enq_port_mask, tx_ready,
    input  enq_ready, tx_pkt, tx_valid
  );

  modport slave (
    input  enq_valid, enq_pkt, enq_port_mask, tx_ready,
    output enq_ready, tx_pkt, tx_valid
  );
endinterface

// File: rtl/noc_tx_port_queue.sv
// Per-core egress queue: stamps src_id and fans each packet out atomically into N/S/E/W FIFOs.
// Define NOC_TX_STATS_EN to build the per-direction saturating sent counters.
`timescale 1ns/1ps

module noc_tx_port_queue
  import noc_tx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CORE_ID = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  noc_tx_port_queue_if.slave           bus,
  output logic [3:0][$clog2(DEPTH):0]  occupancy,
  output logic [15:0]                  drop_count,
  output logic [3:0][15:0]             sent_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  noc_packet_t         mem [4][DEPTH];
  logic [3:0][AW-1:0]  rd_ptr;
  logic [3:0][AW-1:0]  wr_ptr;
  logic [3:0][OW-1:0]  occ;
  logic [3:0]          room;
  logic [3:0]          push;
  logic [3:0]          pop;
  logic [3:0]          vld;
  logic                accept;
  noc_packet_t         stamped;

  always_comb begin
    stamped        = bus.enq_pkt;
    stamped.src_id = SRC_W'(CORE_ID);
  end

  // Room is judged on this cycle's occupancy only, so a full FIFO that is draining still blocks.
  always_comb begin
    room = '0;
    for (int p = 0; p < 4; p++) begin
      room[p] = !bus.enq_port_mask[p] || (occ[p] < OW'(DEPTH));
    end
  end

  assign bus.enq_ready = !flush && (&room);
  assign accept        = bus.enq_valid && bus.enq_ready;
  assign push          = accept ? bus.enq_port_mask : 4'b0000;
  assign pop           = flush ? 4'b0000 : (vld & bus.tx_ready);

  always_comb begin
    vld        = '0;
    bus.tx_pkt = '0;
    for (int p = 0; p < 4; p++) begin
      vld[p] = (occ[p] != '0);
      if (vld[p]) begin
        bus.tx_pkt[p] = mem[p][rd_ptr[p]];
      end
    end
  end

  assign bus.tx_valid = vld;
  assign occupancy    = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
        case ({push[p], pop[p]})
          2'b10:   occ[p] <= occ[p] + OW'(1);
          2'b01:   occ[p] <= occ[p] - OW'(1);
          default: occ[p] <= occ[p];
        endcase
      end
    end
  end

  // Storage carries no reset; tx_pkt is masked to zero whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= stamped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (accept && (bus.enq_port_mask == 4'b0000) && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

`ifdef NOC_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_count <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (pop[p] && (sent_count[p] != 16'hFFFF)) sent_count[p] <= sent_count[p] + 16'd1;
      end
    end
  end
`else
  assign sent_count = '0;
`endif

endmodule

// File: tb/tb_noc_tx_port_queue.sv
// Bench for noc_tx_port_queue: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_noc_tx_port_queue;
  import noc_tx_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CORE_ID = 5;
`ifdef NOC_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [3:0][2:0]  occupancy;
  logic [15:0]      drop_count;
  logic [3:0][15:0] sent_count;

  noc_tx_port_queue_if bus();

  noc_tx_port_queue #(.DEPTH(DEPTH), .CORE_ID(CORE_ID)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .occupancy  (occupancy),
    .drop_count (drop_count),
    .sent_count (sent_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  noc_packet_t mq [4][$];
  int          m_drop;
  int          m_sent [4];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    logic r;
    r = !flush;
    for (int p = 0; p < 4; p++) begin
      if (bus.enq_port_mask[p] && (mq[p].size() >= DEPTH)) r = 1'b0;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 4; p++) begin
      mq[p].delete();
      m_sent[p] = 0;
    end
    m_drop = 0;
  endtask

  task automatic check_outputs();
    chk("enq_ready", bus.enq_ready, model_ready());
    chk("drop_count", drop_count, m_drop);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("tx_valid[%0d]", p), bus.tx_valid[p], mq[p].size() > 0);
      chk($sformatf("occupancy[%0d]", p), occupancy[p], mq[p].size());
      chk($sformatf("sent_count[%0d]", p), sent_count[p], STATS ? m_sent[p] : 0);
      if (mq[p].size() > 0) chk($sformatf("tx_pkt[%0d]", p), bus.tx_pkt[p], mq[p][0]);
    end
  endtask

  task automatic update_model();
    logic        acc;
    noc_packet_t s;
    if (flush) begin
      for (int p = 0; p < 4; p++) mq[p].delete();
      return;
    end
    acc = bus.enq_valid && model_ready();
    for (int p = 0; p < 4; p++) begin
      if (bus.tx_ready[p] && (mq[p].size() > 0)) begin
        void'(mq[p].pop_front());
        if (m_sent[p] < 65535) m_sent[p]++;
      end
    end
    if (acc) begin
      if (bus.enq_port_mask == 4'b0000) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        s        = bus.enq_pkt;
        s.src_id = 4'(CORE_ID);
        for (int p = 0; p < 4; p++) if (bus.enq_port_mask[p]) mq[p].push_back(s);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fl, input logic v, input logic [3:0] mask,
                       input logic [15:0] pl, input logic [3:0] rdy);
    noc_packet_t k;
    k.msg_type        = msg_type_t'(pl[15:14]);
    k.src_id          = 4'hF;
    k.dst_id          = pl[3:0] ^ 4'h5;
    k.payload         = pl;
    flush             = fl;
    bus.enq_valid     = v;
    bus.enq_port_mask = mask;
    bus.enq_pkt       = k;
    bus.tx_ready      = rdy;
  endtask

  // Inputs are set at posedge+1; outputs are compared at the falling edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 4'h0);
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_valid", bus.tx_valid, 4'h0);
    chk("reset_tx_pkt", bus.tx_pkt, '0);
    chk("reset_occupancy", occupancy, '0);
    chk("reset_drop", drop_count, 16'h0);
    chk("reset_sent", sent_count, '0);
    chk("reset_enq_ready", bus.enq_ready, 1'b1);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fl;
    logic        v;
    logic [3:0]  mask;
    logic [15:0] pl;
    logic [3:0]  rdy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [11:0] exp_occ;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Expected fields describe the cycle in which the row's inputs are applied.
    vecs[0]  = '{1'b0, 1'b1, 4'b0010, 16'h00A5, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0010, 12'o0010, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 4'b1000, 16'h0011, 4'b0010, 1'b1, 4'b0010, 12'o0010, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 4'b1000, 16'h0022, 4'b1000, 1'b1, 4'b1000, 12'o1000, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b1000, 12'o1000, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b1000, 1'b1, 4'b1000, 12'o1000, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd2};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd3};
    vecs[9]  = '{1'b0, 1'b1, 4'b0100, 16'h0033, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 4'b0100, 16'h0044, 4'b0000, 1'b1, 4'b0100, 12'o0100, 16'd3};
    vecs[11] = '{1'b1, 1'b1, 4'b0100, 16'h0055, 4'b0100, 1'b0, 4'b0100, 12'o0200, 16'd3};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 4'b0000, 1'b1, 4'b0000, 12'o0000, 16'd3};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].fl, vecs[i].v, vecs[i].mask, vecs[i].pl, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_enq_ready", i), bus.enq_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_tx_valid", i), bus.tx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].exp_occ);
      chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].exp_drop);
      if (i == 1) begin
        chk("vec1_e_payload", bus.tx_pkt[1].payload, 16'h00A5);
        chk("vec1_e_src_id", bus.tx_pkt[1].src_id, 4'(CORE_ID));
      end
      if (i == 4) chk("vec4_n_head", bus.tx_pkt[3].payload, 16'h0022);
      step();
    end

    // Broadcast until every direction is full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 4'hF, 16'h0100 + 16'(i), 4'h0);
      step();
    end
    drive(1'b0, 1'b1, 4'hF, 16'h01FF, 4'h0);
    #1;
    chk("bcast_occ", occupancy, 12'o4444);
    chk("bcast_block", bus.enq_ready, 1'b0);
    step();

    // Drain W only; others stay full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 4'h0, 16'h0, 4'h1);
      #1;
      chk("w_order", bus.tx_pkt[0].payload, 16'h0100 + 16'(i));
      step();
    end
    drive(1'b0, 1'b1, 4'h1, 16'h0200, 4'h0);
    #1;
    chk("w_enq_ok", bus.enq_ready, 1'b1);
    step();
    drive(1'b0, 1'b1, 4'h3, 16'h0201, 4'h0);
    #1;
    chk("ew_blocked", bus.enq_ready, 1'b0);
    step();

    // Full E draining in the same cycle still refuses the enqueue.
    drive(1'b0, 1'b1, 4'h2, 16'h0202, 4'h2);
    #1;
    chk("e_drain_block", bus.enq_ready, 1'b0);
    chk("e_occ_before", occupancy[1], 3'd4);
    step();
    chk("e_occ_after", occupancy[1], 3'd3);

    drive(1'b0, 1'b0, 4'h0, 16'h0, 4'hF);
    repeat (6) step();

    // Five pops on S from a clean reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'h4, 16'h0300 + 16'(i), 4'h4);
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 4'h4);
    repeat (2) step();
    chk("s_sent_5", sent_count[2], STATS ? 16'd5 : 16'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'(i + 9), 16'h0400 + 16'(i), 4'b0101);
      step();
    end
    drive(1'b0, 1'b1, 4'hF, 16'h0410, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", bus.tx_valid, 4'h0);
    chk("async_rst_tx_pkt", bus.tx_pkt, '0);
    chk("async_rst_occ", occupancy, '0);
    chk("async_rst_drop", drop_count, 16'h0);
    chk("async_rst_sent", sent_count, '0);
    model_clear();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step();

    // Randomized traffic with phases of light and heavy back-pressure.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rdy;
      int         bias;
      bias = ((i / 100) % 2 == 0) ? 3 : 1;
      for (int p = 0; p < 4; p++) rdy[p] = ($urandom_range(0, 3) < bias);
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), 16'($urandom), rdy);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
